// File: rtl/db_pkg.sv
// Shared types for the debug-target emulator: command codes, FSM states,
// the busy read-back pattern and the strobe priority encoder.
package db_pkg;

  typedef enum logic [2:0] {
    CMD_NONE   = 3'd0,
    CMD_PAUSE  = 3'd1,
    CMD_RESUME = 3'd2,
    CMD_RESET  = 3'd3,
    CMD_REG_RD = 3'd4,
    CMD_REG_WR = 3'd5,
    CMD_MEM_RD = 3'd6,
    CMD_MEM_WR = 3'd7
  } cmd_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [31:0] D_RD_BUSY = 32'hFFFF_FFFF;

  // strobes = {pause, resume, reset, reg_rd, reg_wr, mem_rd, mem_wr}
  function automatic cmd_t cmd_select(input logic [6:0] strobes);
    cmd_t c;
    c = CMD_NONE;
    if (strobes[6])      c = CMD_PAUSE;
    else if (strobes[5]) c = CMD_RESUME;
    else if (strobes[4]) c = CMD_RESET;
    else if (strobes[3]) c = CMD_REG_RD;
    else if (strobes[2]) c = CMD_REG_WR;
    else if (strobes[1]) c = CMD_MEM_RD;
    else if (strobes[0]) c = CMD_MEM_WR;
    return c;
  endfunction

endpackage

// File: rtl/db_mem_model.sv
// Byte-lane target memory: four 8-bit banks, synchronous per-lane write,
// combinational masked read and an in-range flag for the word index.
module db_mem_model
  import db_pkg::*;
#(
  parameter int MEM_SIZE_WORDS = 64
) (
  input  logic        clk,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [29:0] word_idx,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        in_range
);

  localparam int AW = (MEM_SIZE_WORDS > 1) ? $clog2(MEM_SIZE_WORDS) : 1;

  logic [AW-1:0] idx;

  assign in_range = {2'b00, word_idx} < 32'(MEM_SIZE_WORDS);
  assign idx      = word_idx[AW-1:0];

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] bank [MEM_SIZE_WORDS];

    always_ff @(posedge clk) begin
      if (we && be[gi]) begin
        bank[idx] <= wdata[8*gi +: 8];
      end
    end

    // Unselected lanes read as zero; selected lanes stay in place.
    assign rdata[8*gi +: 8] = be[gi] ? bank[idx] : 8'h00;
  end

endmodule

// File: rtl/db_target_emu.sv
// Debug-target emulator: command FSM with programmable busy latency, register
// file, byte-lane memory and a free-running PC with pause/resume/reset.
module db_target_emu
  import db_pkg::*;
#(
  parameter int MEM_SIZE_WORDS = 64,
  parameter int NUM_REGS       = 32,
  parameter int BUSY_CYCLES    = 16,
  parameter int PC_STEP_CYCLES = 5000000,
  parameter int PC_STEP        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic        pause,
  input  logic        resume,
  input  logic        reset,
  input  logic        reg_rd,
  input  logic        reg_wr,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [3:0]  mem_be,
  input  logic [31:0] addr,
  input  logic [31:0] d_in,
  output logic [31:0] d_rd,
  output logic        busy,
  output logic        error,
  output logic [31:0] pc,
  output logic        paused,
  output logic [15:0] led
);

  localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  state_t      state_q, state_d;
  cmd_t        last_cmd_q, last_cmd_d, cmd;
  logic [31:0] busy_cnt_q, busy_cnt_d;
  logic [31:0] step_cnt_q, step_cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] d_rd_q, d_rd_d;
  logic        error_q, error_d;
  logic        paused_q, paused_d;
  logic        seen_q, seen_d;

  logic          accept, step_due, reg_in_range, reg_we, mem_we, mem_in_range;
  logic [31:0]   mem_rdata, reg_rdata;
  logic [RW-1:0] reg_idx;
  logic [31:0]   regs [NUM_REGS];

  assign cmd          = cmd_select({pause, resume, reset, reg_rd, reg_wr, mem_rd, mem_wr});
  assign accept       = valid && (state_q == ST_IDLE);
  assign step_due     = !paused_q && (step_cnt_q == 32'(PC_STEP_CYCLES - 1));
  assign reg_idx      = addr[RW-1:0];
  assign reg_in_range = addr < 32'(NUM_REGS);
  assign reg_rdata    = (reg_in_range && addr != 32'd0) ? regs[reg_idx] : 32'd0;
  assign reg_we       = accept && (cmd == CMD_REG_WR) && reg_in_range && (addr != 32'd0);
  assign mem_we       = accept && (cmd == CMD_MEM_WR) && mem_in_range;

  db_mem_model #(
    .MEM_SIZE_WORDS(MEM_SIZE_WORDS)
  ) u_mem (
    .clk      (clk),
    .we       (mem_we),
    .be       (mem_be),
    .word_idx (addr[31:2]),
    .wdata    (d_in),
    .rdata    (mem_rdata),
    .in_range (mem_in_range)
  );

  always_ff @(posedge clk) begin
    if (reg_we) begin
      regs[reg_idx] <= d_in;
    end
  end

  always_comb begin
    state_d    = state_q;
    busy_cnt_d = busy_cnt_q;
    step_cnt_d = step_cnt_q;
    pc_d       = pc_q;
    paused_d   = paused_q;
    d_rd_d     = d_rd_q;
    error_d    = error_q;
    last_cmd_d = last_cmd_q;
    seen_d     = seen_q;

    if (state_q == ST_BUSY) begin
      if (busy_cnt_q == 32'd1) begin
        state_d    = ST_IDLE;
        busy_cnt_d = 32'd0;
      end else begin
        busy_cnt_d = busy_cnt_q - 32'd1;
      end
    end

    if (!paused_q) begin
      if (step_due) begin
        step_cnt_d = 32'd0;
        pc_d       = pc_q + 32'(PC_STEP);
      end else begin
        step_cnt_d = step_cnt_q + 32'd1;
      end
    end

    // Every effect of a command commits on its accept edge.
    if (accept) begin
      state_d    = ST_BUSY;
      busy_cnt_d = 32'(BUSY_CYCLES);
      last_cmd_d = cmd;
      seen_d     = 1'b1;
      d_rd_d     = 32'd0;
      error_d    = 1'b0;
      case (cmd)
        CMD_PAUSE: begin
          paused_d   = 1'b1;
          pc_d       = pc_q;
          step_cnt_d = step_cnt_q;
        end
        CMD_RESUME: paused_d = 1'b0;
        CMD_RESET: begin
          pc_d       = 32'd0;
          step_cnt_d = 32'd0;
        end
        CMD_REG_RD: begin
          d_rd_d  = reg_rdata;
          error_d = !reg_in_range;
        end
        CMD_REG_WR: error_d = !reg_in_range;
        CMD_MEM_RD: begin
          d_rd_d  = mem_in_range ? mem_rdata : 32'd0;
          error_d = !mem_in_range;
        end
        CMD_MEM_WR: error_d = !mem_in_range;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      busy_cnt_q <= 32'd0;
      step_cnt_q <= 32'd0;
      pc_q       <= 32'd0;
      paused_q   <= 1'b0;
      d_rd_q     <= 32'd0;
      error_q    <= 1'b0;
      last_cmd_q <= CMD_NONE;
      seen_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_cnt_q <= busy_cnt_d;
      step_cnt_q <= step_cnt_d;
      pc_q       <= pc_d;
      paused_q   <= paused_d;
      d_rd_q     <= d_rd_d;
      error_q    <= error_d;
      last_cmd_q <= last_cmd_d;
      seen_q     <= seen_d;
    end
  end

  assign busy   = valid | (state_q != ST_IDLE);
  assign d_rd   = busy ? D_RD_BUSY : d_rd_q;
  assign error  = error_q;
  assign pc     = pc_q;
  assign paused = paused_q;
  assign led    = {busy, pc_q[5:2], 6'd0, 1'b0, last_cmd_q, seen_q};

endmodule

// File: tb/tb_db_target_emu.sv
// Bench for db_target_emu: scoreboard-checked command table plus hand-written
// sequences for PC stepping, held strobes during busy and mid-command reset.
module tb_db_target_emu;

  localparam logic [6:0] S_NONE  = 7'b0000000;
  localparam logic [6:0] S_PAUSE = 7'b1000000;
  localparam logic [6:0] S_RESUM = 7'b0100000;
  localparam logic [6:0] S_RESET = 7'b0010000;
  localparam logic [6:0] S_REGRD = 7'b0001000;
  localparam logic [6:0] S_REGWR = 7'b0000100;
  localparam logic [6:0] S_MEMRD = 7'b0000010;
  localparam logic [6:0] S_MEMWR = 7'b0000001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [6:0]  stb;
  logic [3:0]  mem_be;
  logic [31:0] addr, d_in;
  logic [31:0] d_rd, pc;
  logic        busy, error, paused;
  logic [15:0] led;

  typedef struct {
    logic [31:0] d;
    logic        err;
  } exp_t;

  typedef struct {
    logic [6:0]  s;
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] din;
    logic [31:0] exp_d;
    logic        exp_err;
  } vec_t;

  exp_t sb[$];
  vec_t vec[22];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  db_target_emu #(
    .MEM_SIZE_WORDS(64),
    .NUM_REGS(32),
    .BUSY_CYCLES(4),
    .PC_STEP_CYCLES(8),
    .PC_STEP(4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid  (valid),
    .pause  (stb[6]),
    .resume (stb[5]),
    .reset  (stb[4]),
    .reg_rd (stb[3]),
    .reg_wr (stb[2]),
    .mem_rd (stb[1]),
    .mem_wr (stb[0]),
    .mem_be (mem_be),
    .addr   (addr),
    .d_in   (d_in),
    .d_rd   (d_rd),
    .busy   (busy),
    .error  (error),
    .pc     (pc),
    .paused (paused),
    .led    (led)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got d_rd %h", name, d_rd);
    end else begin
      e = sb.pop_front();
      check32({name, " d_rd"}, d_rd, e.d);
      check32({name, " error"}, {31'd0, error}, {31'd0, e.err});
    end
  endtask

  // Issue one command from a point just after a negedge; returns 1ns after
  // the negedge at which busy was first seen low again.
  task automatic do_cmd(input string name, input logic [6:0] s, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] din,
                        input logic [31:0] exp_d, input logic exp_err);
    exp_t e;
    int   n;
    logic rd_ok;
    e.d = exp_d;
    e.err = exp_err;
    sb.push_back(e);
    stb = s; addr = a; mem_be = be; d_in = din; valid = 1'b1;
    #1;
    check32({name, " busy_on_valid"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    valid = 1'b0; stb = S_NONE;
    #1;
    n = 1;
    rd_ok = 1'b1;
    while (busy === 1'b1 && n < 100) begin
      if (d_rd !== 32'hFFFF_FFFF) rd_ok = 1'b0;
      n++;
      @(negedge clk);
      #1;
    end
    check32({name, " busy_cycles"}, 32'(n), 32'd5);
    check32({name, " d_rd_busy"}, {31'd0, rd_ok}, 32'd1);
    pop_check(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; valid = 1'b0; stb = S_NONE; mem_be = 4'h0; addr = '0; d_in = '0;

    vec[0]  = '{S_MEMWR, 32'h10,  4'hF, 32'h1122_3344, 32'h0000_0000, 1'b0};
    vec[1]  = '{S_MEMRD, 32'h10,  4'hF, 32'h0,         32'h1122_3344, 1'b0};
    vec[2]  = '{S_MEMWR, 32'h10,  4'h2, 32'hAABB_CCDD, 32'h0000_0000, 1'b0};
    vec[3]  = '{S_MEMRD, 32'h10,  4'hF, 32'h0,         32'h1122_CC44, 1'b0};
    vec[4]  = '{S_MEMRD, 32'h10,  4'h4, 32'h0,         32'h0022_0000, 1'b0};
    vec[5]  = '{S_MEMRD, 32'h13,  4'hF, 32'h0,         32'h1122_CC44, 1'b0};
    vec[6]  = '{S_REGWR, 32'h0,   4'h0, 32'h5,         32'h0,         1'b0};
    vec[7]  = '{S_REGRD, 32'h0,   4'h0, 32'h0,         32'h0,         1'b0};
    vec[8]  = '{S_REGWR, 32'd32,  4'h0, 32'h9,         32'h0,         1'b1};
    vec[9]  = '{S_REGWR, 32'h3,   4'h0, 32'h7,         32'h0,         1'b0};
    vec[10] = '{S_REGRD, 32'h3,   4'h0, 32'h0,         32'h7,         1'b0};
    vec[11] = '{S_REGRD, 32'd32,  4'h0, 32'h0,         32'h0,         1'b1};
    vec[12] = '{S_MEMRD, 32'd256, 4'hF, 32'h0,         32'h0,         1'b1};
    vec[13] = '{S_MEMWR, 32'h0,   4'hF, 32'h55AA_55AA, 32'h0,         1'b0};
    vec[14] = '{S_MEMWR, 32'd256, 4'hF, 32'hDEAD_BEEF, 32'h0,         1'b1};
    vec[15] = '{S_NONE,  32'h0,   4'hF, 32'h0,         32'h0,         1'b0};
    vec[16] = '{S_MEMRD, 32'h0,   4'hF, 32'h0,         32'h55AA_55AA, 1'b0};
    vec[17] = '{S_MEMWR, 32'hFC,  4'h8, 32'h9A00_0000, 32'h0,         1'b0};
    vec[18] = '{S_MEMRD, 32'hFC,  4'h8, 32'h0,         32'h9A00_0000, 1'b0};
    vec[19] = '{S_REGRD | S_MEMRD, 32'h3, 4'hF, 32'h0, 32'h7,         1'b0};
    vec[20] = '{S_REGWR, 32'd31,  4'h0, 32'hCAFE_F00D, 32'h0,         1'b0};
    vec[21] = '{S_REGRD, 32'd31,  4'h0, 32'h0,         32'hCAFE_F00D, 1'b0};

    repeat (2) @(negedge clk);
    #1;
    check32("rst busy",   {31'd0, busy},   32'd0);
    check32("rst d_rd",   d_rd,            32'd0);
    check32("rst error",  {31'd0, error},  32'd0);
    check32("rst pc",     pc,              32'd0);
    check32("rst paused", {31'd0, paused}, 32'd0);
    check32("rst led",    {16'd0, led},    32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    do_cmd("pre_wr", S_MEMWR, 32'h40, 4'hF, 32'h600D_F00D, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // PC stepping with PC_STEP_CYCLES=8, PC_STEP=4
    repeat (24) @(negedge clk);
    check32("pc after 24", pc, 32'd12);
    do_cmd("pause", S_PAUSE, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0);
    check32("paused set", {31'd0, paused}, 32'd1);
    check32("pc at pause", pc, 32'd12);
    repeat (40) @(negedge clk);
    check32("pc frozen", pc, 32'd12);
    do_cmd("resume", S_RESUM, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0);
    check32("paused clr", {31'd0, paused}, 32'd0);
    repeat (4) @(negedge clk);
    check32("pc resumed", pc, 32'd16);
    do_cmd("pc_reset", S_RESET, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0);
    check32("pc zeroed", pc, 32'd0);
    repeat (3) @(negedge clk);
    check32("pc cnt restarted", pc, 32'd0);
    @(negedge clk);
    check32("pc first step", pc, 32'd4);
    check32("led", {16'd0, led}, 32'h0000_0807);

    // Step counter now at 0: the 8th edge is a step edge. Pause+mem_wr held through busy.
    repeat (7) @(negedge clk);
    begin
      exp_t e;
      e.d = 32'h0; e.err = 1'b0;
      sb.push_back(e);
    end
    stb = S_PAUSE | S_MEMWR; addr = 32'h40; mem_be = 4'hF; d_in = 32'h0; valid = 1'b1;
    n = 0;
    repeat (4) begin
      #1;
      if (busy === 1'b1) n++;
      @(negedge clk);
    end
    valid = 1'b0; stb = S_NONE;
    #1;
    if (busy === 1'b1) n++;
    @(negedge clk);
    #1;
    check32("held busy_cycles", 32'(n), 32'd5);
    check32("held busy low", {31'd0, busy}, 32'd0);
    check32("held pc no step", pc, 32'd4);
    check32("held paused", {31'd0, paused}, 32'd1);
    check32("held led cmd", {28'd0, led[4:1]}, 32'd1);
    pop_check("held");
    do_cmd("held no write", S_MEMRD, 32'h40, 4'hF, 32'h0, 32'h600D_F00D, 1'b0);

    for (int i = 0; i < 22; i++) begin
      do_cmd($sformatf("vec%0d", i), vec[i].s, vec[i].a, vec[i].be, vec[i].din,
             vec[i].exp_d, vec[i].exp_err);
    end

    // rst_n asserted while the FSM is busy with an already committed write
    stb = S_MEMWR; addr = 32'h20; mem_be = 4'hF; d_in = 32'h1234_5678; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0; stb = S_NONE;
    #1;
    check32("mid busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check32("abort busy",   {31'd0, busy},   32'd0);
    check32("abort pc",     pc,              32'd0);
    check32("abort paused", {31'd0, paused}, 32'd0);
    check32("abort d_rd",   d_rd,            32'd0);
    check32("abort led",    {16'd0, led},    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    do_cmd("kept write", S_MEMRD, 32'h20, 4'hF, 32'h0, 32'h1234_5678, 1'b0);
    do_cmd("kept reg",   S_REGRD, 32'h3,  4'h0, 32'h0, 32'h7,         1'b0);

    check32("sb drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
